// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_unit_pkg
// Brief   : Shared types and constants for the instruction fetch stage.
// Revision: 1.0 - initial release
// ============================================================================
package instr_fetch_unit_pkg;

    localparam int FETCH_ADDR_W  = 32;
    localparam int FETCH_INSTR_W = 32;
    localparam logic [FETCH_INSTR_W-1:0] DEFAULT_NOP = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_HOLD   = 3'd2,
        ST_HALTED = 3'd3,
        ST_FAULT  = 3'd4
    } fetch_state_e;

    function automatic logic is_aligned(input logic [1:0] pc_lsb);
        return (pc_lsb == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_unit_if
// Brief   : Instruction-memory read bus (req/ack handshake).
// Revision: 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_unit
// Brief   : Multi-cycle fetch stage: one imem read per instruction, IR hold.
// Revision: 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W      = FETCH_ADDR_W,
    parameter int                DATA_W      = FETCH_INSTR_W,
    parameter int                ACK_TIMEOUT = 16,
    parameter logic [DATA_W-1:0] NOP_INSTR   = DEFAULT_NOP
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic [ADDR_W-1:0] cur_pc,
    output logic                   pc_wre,
    instr_fetch_unit_if.master     imem,
    output logic                   if_valid,
    output logic [DATA_W-1:0]      if_instr,
    output logic [ADDR_W-1:0]      if_pc,
    input  wire logic              id_ready,
    input  wire logic              flush,
    input  wire logic              halt,
    output logic                   fetch_fault
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    fetch_state_e      state,    state_nxt;
    logic              req_q,    req_nxt;
    logic [ADDR_W-1:0] addr_q,   addr_nxt;
    logic              valid_q,  valid_nxt;
    logic [DATA_W-1:0] instr_q,  instr_nxt;
    logic [ADDR_W-1:0] pc_q,     pc_nxt;
    logic              fault_q,  fault_nxt;
    logic              drop_q,   drop_nxt;
    logic [CNT_W-1:0]  cnt_q,    cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            fault_q <= 1'b0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nxt;
            req_q   <= req_nxt;
            addr_q  <= addr_nxt;
            valid_q <= valid_nxt;
            instr_q <= instr_nxt;
            pc_q    <= pc_nxt;
            fault_q <= fault_nxt;
            drop_q  <= drop_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_nxt   = req_q;
        addr_nxt  = addr_q;
        valid_nxt = valid_q;
        instr_nxt = instr_q;
        pc_nxt    = pc_q;
        fault_nxt = fault_q;
        drop_nxt  = drop_q;
        cnt_nxt   = cnt_q;
        case (state)
            ST_IDLE: begin
                if (halt) begin
                    state_nxt = ST_HALTED;
                end else if (!is_aligned(cur_pc[1:0])) begin
                    fault_nxt = 1'b1;
                    state_nxt = ST_FAULT;
                end else begin
                    addr_nxt  = cur_pc;
                    req_nxt   = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem.ack) begin
                    req_nxt  = 1'b0;
                    cnt_nxt  = '0;
                    drop_nxt = 1'b0;
                    if (!drop_q && !flush) begin
                        instr_nxt = imem.rdata;
                        pc_nxt    = addr_q;
                        valid_nxt = 1'b1;
                        state_nxt = ST_HOLD;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    req_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    drop_nxt  = 1'b0;
                    fault_nxt = 1'b1;
                    state_nxt = ST_FAULT;
                end else begin
                    // A flushed request still runs to completion; its data is discarded.
                    cnt_nxt = cnt_q + 1'b1;
                    if (flush) drop_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    valid_nxt = 1'b0;
                    instr_nxt = NOP_INSTR;
                    state_nxt = ST_IDLE;
                end else if (id_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            ST_HALTED: begin
                if (!halt) state_nxt = ST_IDLE;
            end
            ST_FAULT: begin
                if (flush) begin
                    fault_nxt = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign pc_wre      = valid_q & id_ready & ~flush;
    assign imem.req    = req_q;
    assign imem.addr   = addr_q;
    assign if_valid    = valid_q;
    assign if_instr    = instr_q;
    assign if_pc       = pc_q;
    assign fetch_fault = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_fetch_unit
// Brief   : Directed bench for instr_fetch_unit with a behavioural fetch model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int TIMEOUT = 16;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, halt, flush, id_ready;
    logic [31:0] cur_pc;
    logic        pc_wre, if_valid, fetch_fault;
    logic [31:0] if_instr, if_pc;

    int n_cmp = 0;
    int n_fail = 0;
    int n_wre = 0;
    int lat = 1;
    int mcnt = 0;
    bit wre_flag = 1'b0;
    logic [31:0] mem [logic [31:0]];

    instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) imem_bus ();

    instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .ACK_TIMEOUT(TIMEOUT), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .cur_pc(cur_pc), .pc_wre(pc_wre), .imem(imem_bus),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
        .flush(flush), .halt(halt), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (32'hBAD0_0000 | a);
    endfunction

    // Memory with programmable latency, plus the PC register stepping by 4 on pc_wre.
    always @(posedge clk) begin
        #1;
        if (wre_flag) cur_pc = cur_pc + 32'd4;
        if (imem_bus.req && !imem_bus.ack) begin
            if (mcnt == lat) begin
                imem_bus.ack   = 1'b1;
                imem_bus.rdata = mem_rd(imem_bus.addr);
                mcnt = 0;
            end else begin
                mcnt++;
            end
        end else begin
            imem_bus.ack = 1'b0;
            mcnt = 0;
        end
    end

    // Behavioural model: what the fetch stage must show, derived from the handshake rules.
    bit          live = 1'b0;
    bit          m_req, m_valid, m_fault, m_halted, m_doomed;
    int          m_age;
    logic [31:0] m_addr, m_instr, m_pc;

    always @(negedge clk) begin
        if (live) begin
            check("imem_req", imem_bus.req, m_req);
            if (m_req) check("imem_addr", imem_bus.addr, m_addr);
            check("if_valid", if_valid, m_valid);
            check("if_instr", if_instr, m_instr);
            check("if_pc", if_pc, m_pc);
            check("fetch_fault", fetch_fault, m_fault);
            check("pc_wre", pc_wre, m_valid & id_ready & ~flush);
        end
        wre_flag = (pc_wre === 1'b1);
        if (wre_flag) n_wre++;
        if (reset) begin
            {m_req, m_valid, m_fault, m_halted, m_doomed} = '0;
            m_age = 0; m_addr = '0; m_instr = NOP; m_pc = '0;
            live = 1'b1;
        end else if (m_fault) begin
            if (flush) m_fault = 1'b0;
        end else if (m_halted) begin
            if (!halt) m_halted = 1'b0;
        end else if (m_valid) begin
            if (flush) begin m_valid = 1'b0; m_instr = NOP; end
            else if (id_ready) m_valid = 1'b0;
        end else if (m_req) begin
            if (imem_bus.ack) begin
                m_req = 1'b0;
                if (!m_doomed && !flush) begin
                    m_valid = 1'b1; m_instr = imem_bus.rdata; m_pc = m_addr;
                end
            end else if (m_age + 1 >= TIMEOUT) begin
                m_req = 1'b0; m_fault = 1'b1;
            end else begin
                m_age++;
                m_doomed = m_doomed | flush;
            end
        end else if (halt) begin
            m_halted = 1'b1;
        end else if (cur_pc[1:0] != 2'b00) begin
            m_fault = 1'b1;
        end else begin
            m_req = 1'b1; m_addr = cur_pc; m_age = 0; m_doomed = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base, iter, nreq;
        reset = 1'b1; halt = 1'b0; flush = 1'b0; id_ready = 1'b1; cur_pc = 32'h0;
        imem_bus.ack = 1'b0; imem_bus.rdata = '0;
        mem[32'h0]   = 32'h0240_0001;
        mem[32'h4]   = 32'h1111_0004;
        mem[32'h8]   = 32'h2222_0008;
        mem[32'h10]  = 32'hAAAA_0010;
        mem[32'h20]  = 32'h3333_0020;
        mem[32'h40]  = 32'h4444_0040;
        mem[32'h100] = 32'hBBBB_0100;

        // Single fetch, ack one cycle after request
        lat = 1;
        tick(2);
        reset = 1'b0;
        check("rst_req", imem_bus.req, 1'b0);
        check("rst_valid", if_valid, 1'b0);
        check("rst_instr", if_instr, NOP);
        check("rst_fault", fetch_fault, 1'b0);
        base = n_wre;
        tick(1); check("t1_req_c1", imem_bus.req, 1'b1);
        tick(1); check("t1_valid_c2", if_valid, 1'b0);
        tick(1);
        check("t1_valid_c3", if_valid, 1'b1);
        check("t1_instr_c3", if_instr, 32'h0240_0001);
        check("t1_pc_c3", if_pc, 32'h0);
        tick(1);
        halt = 1'b1;
        check("t1_wre_once", n_wre - base, 1);
        tick(2);
        check("t1_halted_req", imem_bus.req, 1'b0);
        check("t1_wre_still_once", n_wre - base, 1);

        // Back-to-back 0,4,8 with latency 3: 6 cycles per instruction
        cur_pc = 32'h0; lat = 3; halt = 1'b0; base = n_wre; iter = 0;
        do begin tick(1); iter++; end while (n_wre - base < 3 && iter < 60);
        halt = 1'b1;
        check("t2_wre_count", n_wre - base, 3);
        check("t2_cycles", iter, 19);
        check("t2_last_pc", if_pc, 32'h8);
        check("t2_last_instr", if_instr, 32'h2222_0008);
        tick(2);

        // Decode stalls for 5 cycles
        cur_pc = 32'h10; lat = 1; id_ready = 1'b0; halt = 1'b0; base = n_wre;
        tick(4);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", if_valid, 1'b1);
            check("t3_hold_instr", if_instr, 32'hAAAA_0010);
            check("t3_hold_noreq", imem_bus.req, 1'b0);
            tick(1);
        end
        check("t3_no_wre_stall", n_wre - base, 0);
        id_ready = 1'b1;
        tick(1);
        halt = 1'b1;
        check("t3_wre_once", n_wre - base, 1);
        check("t3_valid_clr", if_valid, 1'b0);
        tick(1);

        // Flush one cycle into FETCH, then flush coincident with ack
        cur_pc = 32'h20; lat = 3; halt = 1'b0; base = n_wre;
        tick(2);
        check("t4_req_a", imem_bus.req, 1'b1);
        check("t4_addr_a", imem_bus.addr, 32'h20);
        tick(1); flush = 1'b1; cur_pc = 32'h40;
        tick(1); flush = 1'b0;
        tick(2);
        check("t4_dropped", if_valid, 1'b0);
        tick(1);
        check("t4_req_b", imem_bus.req, 1'b1);
        check("t4_addr_b", imem_bus.addr, 32'h40);
        tick(3); flush = 1'b1;
        tick(1); flush = 1'b0; halt = 1'b1;
        check("t4_dropped_coincident", if_valid, 1'b0);
        tick(2);
        check("t4_no_wre", n_wre - base, 0);

        // Misaligned PC, then ack timeout
        cur_pc = 32'h6; halt = 1'b0;
        tick(2);
        check("t5_misalign_fault", fetch_fault, 1'b1);
        check("t5_misalign_noreq", imem_bus.req, 1'b0);
        flush = 1'b1; cur_pc = 32'h80; lat = 1000;
        tick(1); flush = 1'b0;
        check("t5_fault_cleared", fetch_fault, 1'b0);
        tick(1);
        nreq = 0;
        while (imem_bus.req === 1'b1 && nreq < 40) begin nreq++; tick(1); end
        check("t5_req_cycles", nreq, TIMEOUT);
        check("t5_timeout_fault", fetch_fault, 1'b1);
        flush = 1'b1; halt = 1'b1;
        tick(1); flush = 1'b0;
        check("t5_timeout_cleared", fetch_fault, 1'b0);
        tick(1);

        // Halt during FETCH, then reset mid-handshake
        cur_pc = 32'h100; lat = 2; halt = 1'b0; base = n_wre;
        tick(2); halt = 1'b1;
        tick(3);
        check("t6_delivered_valid", if_valid, 1'b1);
        check("t6_delivered_instr", if_instr, 32'hBBBB_0100);
        check("t6_delivered_pc", if_pc, 32'h100);
        tick(3);
        check("t6_halted_noreq", imem_bus.req, 1'b0);
        check("t6_wre_once", n_wre - base, 1);
        cur_pc = 32'h100; halt = 1'b0;
        tick(2);
        check("t6_req_before_rst", imem_bus.req, 1'b1);
        reset = 1'b1;
        tick(1);
        check("t6_rst_req", imem_bus.req, 1'b0);
        check("t6_rst_valid", if_valid, 1'b0);
        check("t6_rst_instr", if_instr, NOP);
        check("t6_rst_pc", if_pc, 32'h0);
        check("t6_rst_fault", fetch_fault, 1'b0);
        reset = 1'b0;
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
